systolic_sparse_feeder: RTL and testbench

- Drives the sparse systolic array's input interface: load_weight, block_valid, a_in_flat and b_in_flat.
- Accepts one block descriptor per valid/ready handshake from the BSR scheduler. Zero blocks are skipped with no buffer reads and no array activity.
- For non-zero blocks: reads the weight tile row by row from the weight buffer, then streams row-skewed activations from the activation buffer, then flushes the pipeline.
- Sits between the act/wgt buffers and the systolic array.

---
 rtl/systolic_sparse_feeder.sv | 157 +++++++++++++++
 tb/tb_systolic_sparse_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sparse_feeder.sv
// Feeds the sparse systolic array from the weight/activation buffers: loads the
// weight tile, streams row-skewed activations, flushes, and skips all-zero blocks.
module systolic_sparse_feeder #(
    parameter int N_ROWS  = 8,
    parameter int N_COLS  = 8,
    parameter int DATA_W  = 8,
    parameter int WADDR_W = 10,
    parameter int AADDR_W = 10,
    parameter int KLEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic                       desc_zero,
    input  logic [WADDR_W-1:0]         desc_wgt_base,
    input  logic [AADDR_W-1:0]         desc_act_base,
    input  logic [KLEN_W-1:0]          desc_k_len,
    output logic                       wgt_rd_en,
    output logic [WADDR_W-1:0]         wgt_rd_addr,
    input  logic [N_COLS*DATA_W-1:0]   wgt_rd_data,
    output logic                       act_rd_en,
    output logic [AADDR_W-1:0]         act_rd_addr,
    input  logic [N_ROWS*DATA_W-1:0]   act_rd_data,
    output logic                       load_weight,
    output logic                       block_valid,
    output logic [N_ROWS*DATA_W-1:0]   a_out_flat,
    output logic [N_COLS*DATA_W-1:0]   b_out_flat,
    output logic                       blk_done,
    output logic                       busy,
    output logic [15:0]                skip_cnt
);

    typedef enum logic [2:0] {IDLE, WLOAD, ACT, FLUSH, DONE} state_t;

    localparam int CNT_W     = 16;
    localparam int FLUSH_LEN = N_ROWS + N_COLS - 2;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WADDR_W-1:0]   wgt_base_q, wgt_base_d;
    logic [AADDR_W-1:0]   act_base_q, act_base_d;
    logic [KLEN_W-1:0]    k_len_q, k_len_d;
    logic [15:0]          skip_q, skip_d;
    logic                 load_q, act_vld_q, bv_q;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wgt_base_d = wgt_base_q;
        act_base_d = act_base_q;
        k_len_d    = k_len_q;
        skip_d     = skip_q;
        unique case (state_q)
            IDLE: begin
                if (desc_valid) begin
                    cnt_d = '0;
                    if (desc_zero || desc_k_len == '0) begin
                        state_d = DONE;
                        if (skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
                    end else begin
                        state_d    = WLOAD;
                        wgt_base_d = desc_wgt_base;
                        act_base_d = desc_act_base;
                        k_len_d    = desc_k_len;
                    end
                end
            end
            WLOAD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_ROWS - 1)) begin
                    state_d = ACT;
                    cnt_d   = '0;
                end
            end
            ACT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q + CNT_W'(1) == CNT_W'(k_len_q)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wgt_rd_en   = (state_q == WLOAD);
        act_rd_en   = (state_q == ACT);
        wgt_rd_addr = wgt_rd_en ? wgt_base_q + WADDR_W'(cnt_q) : '0;
        act_rd_addr = act_rd_en ? act_base_q + AADDR_W'(cnt_q) : '0;
        desc_ready  = (state_q == IDLE);
        busy        = (state_q != IDLE);
        blk_done    = (state_q == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wgt_base_q <= '0;
            act_base_q <= '0;
            k_len_q    <= '0;
            skip_q     <= '0;
            load_q     <= 1'b0;
            act_vld_q  <= 1'b0;
            bv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wgt_base_q <= wgt_base_d;
            act_base_q <= act_base_d;
            k_len_q    <= k_len_d;
            skip_q     <= skip_d;
            // Strobes delayed by the one-cycle buffer read latency.
            load_q     <= wgt_rd_en;
            act_vld_q  <= act_rd_en;
            bv_q       <= (state_q == ACT) || (state_q == FLUSH);
        end
    end

    assign load_weight = load_q;
    assign block_valid = bv_q;
    assign skip_cnt    = skip_q;
    assign b_out_flat  = load_q ? wgt_rd_data : '0;

    for (genvar r = 0; r < N_ROWS; r++) begin : g_lane
        logic [DATA_W-1:0] lane_in;
        assign lane_in = act_vld_q ? act_rd_data[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign a_out_flat[DATA_W-1:0] = lane_in;
        end else begin : g_delay
            logic [DATA_W-1:0] pipe_q [r];
            // NOTE: skew registers are reset so an aborted block leaves no stale data in flight.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int d = 0; d < r; d++) pipe_q[d] <= '0;
                end else begin
                    pipe_q[0] <= lane_in;
                    for (int d = 1; d < r; d++) pipe_q[d] <= pipe_q[d-1];
                end
            end
            assign a_out_flat[r*DATA_W +: DATA_W] = pipe_q[r-1];
        end
    end

endmodule

// File: tb/tb_systolic_sparse_feeder.sv
// Directed bench for systolic_sparse_feeder: cycle-by-cycle expectations for
// processed, skipped, wrapping, back-to-back and reset-aborted blocks.
module tb_systolic_sparse_feeder;

    localparam int N  = 8;
    localparam int M  = 8;
    localparam int DW = 8;
    localparam int WA = 10;
    localparam int AA = 10;
    localparam int KW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              desc_valid, desc_ready, desc_zero;
    logic [WA-1:0]     desc_wgt_base;
    logic [AA-1:0]     desc_act_base;
    logic [KW-1:0]     desc_k_len;
    logic              wgt_rd_en, act_rd_en;
    logic [WA-1:0]     wgt_rd_addr;
    logic [AA-1:0]     act_rd_addr;
    logic [M*DW-1:0]   wgt_rd_data = '0;
    logic [N*DW-1:0]   act_rd_data = '0;
    logic              load_weight, block_valid, blk_done, busy;
    logic [N*DW-1:0]   a_out_flat;
    logic [M*DW-1:0]   b_out_flat;
    logic [15:0]       skip_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;

    systolic_sparse_feeder #(
        .N_ROWS(N), .N_COLS(M), .DATA_W(DW),
        .WADDR_W(WA), .AADDR_W(AA), .KLEN_W(KW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_zero(desc_zero),
        .desc_wgt_base(desc_wgt_base), .desc_act_base(desc_act_base), .desc_k_len(desc_k_len),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .load_weight(load_weight), .block_valid(block_valid),
        .a_out_flat(a_out_flat), .b_out_flat(b_out_flat),
        .blk_done(blk_done), .busy(busy), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    // Buffer contents are a fixed function of the address.
    function automatic logic [M*DW-1:0] wrow(input logic [WA-1:0] a);
        logic [M*DW-1:0] v;
        for (int c = 0; c < M; c++) v[c*DW +: DW] = 8'(a) + 8'(c * 17) + 8'h01;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] acol(input logic [AA-1:0] a);
        logic [N*DW-1:0] v;
        for (int r = 0; r < N; r++) v[r*DW +: DW] = 8'(a) + 8'(r * 33) + 8'h02;
        return v;
    endfunction

    // Buffers hold their last read data, so the DUT must gate idle lanes itself.
    always @(posedge clk) begin
        if (wgt_rd_en) wgt_rd_data <= wrow(wgt_rd_addr);
        if (act_rd_en) act_rd_data <= acol(act_rd_addr);
    end

    always @(negedge clk) if (blk_done) done_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_skip);
        check({tag, " ready"}, 64'(desc_ready), 64'd1);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(blk_done), 64'd0);
        check({tag, " wen/addr"}, 64'({wgt_rd_en, wgt_rd_addr}), 64'd0);
        check({tag, " aen/addr"}, 64'({act_rd_en, act_rd_addr}), 64'd0);
        check({tag, " lw/bv"}, 64'({load_weight, block_valid}), 64'd0);
        check({tag, " a_out"}, 64'(a_out_flat), 64'd0);
        check({tag, " b_out"}, 64'(b_out_flat), 64'd0);
        check({tag, " skip"}, 64'(skip_cnt), 64'(exp_skip));
    endtask

    // Called right after the accepting edge; returns in the IDLE cycle after DONE.
    task automatic check_block(input string tag, input logic [WA-1:0] wb,
                               input logic [AA-1:0] ab, input int k_len,
                               input logic [15:0] exp_skip);
        int done_c = N + k_len + N + M - 2;
        for (int cyc = 0; cyc <= done_c + 1; cyc++) begin
            logic          wen, aen, lw, bv;
            logic [WA-1:0] waddr;
            logic [AA-1:0] aaddr;
            logic [M*DW-1:0] bexp;
            logic [N*DW-1:0] aexp, col;
            string t;
            t     = $sformatf("%s c%0d", tag, cyc);
            wen   = (cyc < N);
            waddr = wen ? WA'(int'(wb) + cyc) : '0;
            lw    = (cyc >= 1) && (cyc <= N);
            bexp  = lw ? wrow(WA'(int'(wb) + cyc - 1)) : '0;
            aen   = (cyc >= N) && (cyc < N + k_len);
            aaddr = aen ? AA'(int'(ab) + cyc - N) : '0;
            bv    = (cyc >= N + 1) && (cyc <= done_c);
            aexp  = '0;
            for (int r = 0; r < N; r++) begin
                int k = cyc - N - 1 - r;
                if (k >= 0 && k < k_len) begin
                    col = acol(AA'(int'(ab) + k));
                    aexp[r*DW +: DW] = col[r*DW +: DW];
                end
            end
            check({t, " wgt"}, 64'({wgt_rd_en, wgt_rd_addr}), 64'({wen, waddr}));
            check({t, " act"}, 64'({act_rd_en, act_rd_addr}), 64'({aen, aaddr}));
            check({t, " lw/bv"}, 64'({load_weight, block_valid}), 64'({lw, bv}));
            check({t, " b_out"}, 64'(b_out_flat), 64'(bexp));
            check({t, " a_out"}, 64'(a_out_flat), 64'(aexp));
            check({t, " rdy/busy/done"}, 64'({desc_ready, busy, blk_done}),
                  64'({cyc == done_c + 1, cyc != done_c + 1, cyc == done_c}));
            check({t, " skip"}, 64'(skip_cnt), 64'(exp_skip));
            if (cyc <= done_c) tick();
        end
    endtask

    // Called right after the accepting edge of a skipped block.
    task automatic check_skip(input string tag, input logic [15:0] exp_skip);
        check({tag, " c0 rdy/busy/done"}, 64'({desc_ready, busy, blk_done}), 64'b011);
        check({tag, " c0 strobes"}, 64'({wgt_rd_en, act_rd_en, load_weight, block_valid}), 64'd0);
        check({tag, " c0 skip"}, 64'(skip_cnt), 64'(exp_skip));
        tick();
        check({tag, " c1 rdy/busy/done"}, 64'({desc_ready, busy, blk_done}), 64'b100);
        check({tag, " c1 strobes"}, 64'({wgt_rd_en, act_rd_en, load_weight, block_valid}), 64'd0);
    endtask

    task automatic set_desc(input logic v, input logic z, input logic [WA-1:0] wb,
                            input logic [AA-1:0] ab, input logic [KW-1:0] k);
        desc_valid    = v;
        desc_zero     = z;
        desc_wgt_base = wb;
        desc_act_base = ab;
        desc_k_len    = k;
    endtask

    initial begin
        int pulses0;
        rst_n = 1'b0;
        set_desc(1'b0, 1'b0, '0, '0, '0);
        repeat (2) tick();
        check_idle("reset", 16'd0);
        rst_n = 1'b1;
        tick();
        check_idle("idle", 16'd0);

        // Default non-zero block.
        pulses0 = done_pulses;
        set_desc(1'b1, 1'b0, 10'h010, 10'h040, 8'd4);
        tick();
        desc_valid = 1'b0;
        check_block("blk1", 10'h010, 10'h040, 4, 16'd0);
        check("blk1 pulses", 64'(done_pulses - pulses0), 64'd1);

        // All-zero block, then a K==0 block: both skipped.
        set_desc(1'b1, 1'b1, 10'h123, 10'h045, 8'd4);
        tick();
        desc_valid = 1'b0;
        check_skip("zero", 16'd1);
        set_desc(1'b1, 1'b0, 10'h010, 10'h040, 8'd0);
        tick();
        desc_valid = 1'b0;
        check_skip("klen0", 16'd2);

        // Address wrap on both buffers.
        set_desc(1'b1, 1'b0, 10'h3FC, 10'h3FE, 8'd3);
        tick();
        desc_valid = 1'b0;
        check_block("wrap", 10'h3FC, 10'h3FE, 3, 16'd2);

        // Reset in the middle of ACT.
        set_desc(1'b1, 1'b0, 10'h010, 10'h040, 8'd4);
        tick();
        desc_valid = 1'b0;
        repeat (10) tick();
        check("midact act_en", 64'(act_rd_en), 64'd1);
        rst_n = 1'b0;
        tick();
        check_idle("abort", 16'd0);
        rst_n = 1'b1;
        set_desc(1'b1, 1'b0, 10'h080, 10'h090, 8'd1);
        tick();
        desc_valid = 1'b0;
        check_block("postrst", 10'h080, 10'h090, 1, 16'd0);

        // Back-to-back with desc_valid held high: non-zero, zero, non-zero.
        pulses0 = done_pulses;
        set_desc(1'b1, 1'b0, 10'h020, 10'h050, 8'd2);
        tick();
        set_desc(1'b1, 1'b1, 10'h000, 10'h000, 8'd7);
        check_block("b2b_a", 10'h020, 10'h050, 2, 16'd0);
        tick();
        set_desc(1'b1, 1'b0, 10'h030, 10'h060, 8'd5);
        check_skip("b2b_z", 16'd1);
        tick();
        desc_valid = 1'b0;
        check_block("b2b_c", 10'h030, 10'h060, 5, 16'd1);
        check("b2b pulses", 64'(done_pulses - pulses0), 64'd3);
        tick();
        check_idle("final", 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
